trace_capture_unit: RTL and testbench
=====================================

# trace_capture_unit

Retirement-event capture buffer that sits directly downstream of the `cpu` writeback/memory stage. It samples the per-cycle commit signals: register write, load, store and halt. It packs each active cycle into one timestamped record, buffers records in a FIFO and drains them over a valid/ready port to a trace consumer. It also keeps the cycle and instruction counters and the sticky overflow/done status.

## Interface
- `DEPTH`, 8, FIFO entries; power of two, ≥2.
- `CYC_W`, 32, width of cycle/instruction counters and record timestamp.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `en`  in  1  capture enable; when 0, events are not recorded and not counted.
- `reg_we`  in  1  register file written this cycle.
- `reg_dst`  in  4  destination register.
- `reg_data`  in  16  data written to register.
- `mem_rd` / `mem_wr`  in  1 each  memory read / write this cycle.
- `mem_addr`  in  16  memory address.
- `mem_wdata`  in  16  store data.
- `mem_rdata`  in  16  load data.
- `halt`  in  1  halt in memory/writeback stage.
- `out_valid`  out  1  head record valid.
- `out_ready`  in  1  consumer accepts head record.
- `out_mask`  out  4  event mask {halt, store, load, reg}.
- `out_reg`  out  4  `reg_dst` of record.
- `out_rdata`  out  16  `reg_data` of record.
- `out_maddr`  out  16  `mem_addr` of record.
- `out_mdata`  out  16  `mem_wdata` if store bit, else `mem_rdata`.
- `out_cycle`  out  CYC_W  timestamp of record.
- `cycle_count`  out  CYC_W  cycles since reset release.
- `inst_count`  out  CYC_W  retired instructions.
- `overflow`  out  1  sticky; a non-halt record was dropped.
- `done`  out  1  halt record consumed; capture closed.

## Operation
- **Event mask:** `{halt, mem_wr, mem_rd, reg_we}`, sampled when `en`=1 and state is CAPTURE. Any bit set produces a record; a zero mask produces none.
- **Both memory strobes:** `mem_rd`=`mem_wr`=1 records both bits; `out_mdata`=`mem_wdata`.
- **Instruction count:** `inst_count` += 1 per captured cycle with `halt | reg_we | mem_wr`. It increments at most once per cycle, even for combined events. `mem_rd` alone does not count.
- **Cycle count:** `cycle_count` increments every cycle while `rst_n`=1, regardless of `en`/state, and wraps modulo 2^CYC_W. The record timestamp is the pre-increment value in the capture cycle.
- **FIFO:** circular, `DEPTH` entries, pointers with an extra wrap bit. Full when pointers are equal except the wrap bit; empty when they are equal.
- **Push rule:** a push is accepted if not full, or if a pop occurs in the same cycle.
- **Overflow:** a non-halt record that cannot be pushed is dropped and `overflow` sets. Counters still advance.
- **Ordering:** records drain strictly in capture order.
- **States:**
  - CAPTURE: normal operation.
  - DRAIN: entered on the first captured `halt`.
  - DONE.
- **Halt handling:** the halt record is never dropped. If it cannot be pushed, it is held in a one-entry pending register and pushed at the first free slot, ahead of nothing (later inputs are ignored). In DRAIN, all inputs except `out_ready` are ignored and counters other than `cycle_count` freeze.
- **DRAIN → DONE:** when the halt record is popped. `done`=1 and stays until reset. `out_valid`=0 in DONE.
- **Transitions:** CAPTURE→DRAIN (halt captured); DRAIN→DONE (halt record popped); any→CAPTURE (reset).

## Timing
- **Reset:** the edge with `rst_n`=0 sets the FIFO empty, pending clear and state CAPTURE. All outputs are 0: `out_valid`, `out_mask`, `out_reg`, `out_rdata`, `out_maddr`, `out_mdata`, `out_cycle`, `cycle_count`, `inst_count`, `overflow`, `done`.
- **Reset mid-drain:** discards all entries with no further `out_valid`.
- **Capture latency:** an event sampled at edge N makes its record visible at `out_valid` after edge N (available cycle N+1) if the FIFO was empty.
- **Handshake:** pop on edge with `out_valid & out_ready`. Output fields are driven from the head entry and stay stable while `out_valid=1` and `out_ready=0`. Back-to-back pops deliver one record per cycle.
- **Simultaneous push and pop:** on empty FIFO, the new record appears the next cycle. On full FIFO, no drop.
- **Pending halt:** pushed on the edge where a slot frees. It becomes head no earlier than the cycle after all prior records pop.

## Test plan
1. **Single reg write:** `en`=1, `reg_we`=1, `reg_dst`=3, `reg_data`=0x1234 at `cycle_count`=5 → next cycle `out_valid`=1, `out_mask`=0001, `out_reg`=3, `out_rdata`=0x1234, `out_cycle`=5, `inst_count`=1; `out_ready`=1 → `out_valid`=0 after.
2. **Load-to-register:** `reg_we`=1, `mem_rd`=1, `mem_addr`=0x0040, `mem_rdata`=0xBEEF → one record, `out_mask`=0011, `out_mdata`=0xBEEF; `inst_count` unchanged by the load bit. Store: `mem_wr`=1, `mem_wdata`=0x00A5 → `out_mask`=0100, `inst_count`+1.
3. **Overflow:** DEPTH=8, `out_ready`=0, 9 consecutive reg writes (data 1..9) → `overflow`=1, `inst_count`=9. Drain yields data 1..8 in order, then `out_valid`=0.
4. **Halt while full:** FIFO full, `out_ready`=0, `halt`=1, then more events → events ignored, `inst_count`+1 for halt only. Assert `out_ready` → 8 records then `out_mask`=1000; `done`=1 the cycle after that pop.
5. **Simultaneous push/pop when full:** `out_ready`=1 and new event on the same edge → no drop, `overflow` stays 0, order preserved.
6. **Reset mid-drain:** 3 entries queued, `rst_n`=0 one cycle → all outputs 0 at the next edge. `en`=0 with events → no records, `inst_count` unchanged, `cycle_count` advances.

Source files
------------

// File: rtl/trace_capture_unit.sv
// trace_capture_unit: captures per-cycle retirement events from the cpu
// writeback/memory stage, timestamps them, buffers them in a circular FIFO
// and drains them to a trace consumer over a valid/ready port.
//
// state    | meaning
// ---------+------------------------------------------------------------
// CAPTURE  | recording events, counting instructions
// DRAIN    | halt captured; inputs ignored, FIFO (and pending halt) drain
// DONE     | halt record consumed; capture closed until reset
module trace_capture_unit #(
    parameter int DEPTH = 8,
    parameter int CYC_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             reg_we,
    input  logic [3:0]       reg_dst,
    input  logic [15:0]      reg_data,
    input  logic             mem_rd,
    input  logic             mem_wr,
    input  logic [15:0]      mem_addr,
    input  logic [15:0]      mem_wdata,
    input  logic [15:0]      mem_rdata,
    input  logic             halt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_mask,
    output logic [3:0]       out_reg,
    output logic [15:0]      out_rdata,
    output logic [15:0]      out_maddr,
    output logic [15:0]      out_mdata,
    output logic [CYC_W-1:0] out_cycle,
    output logic [CYC_W-1:0] cycle_count,
    output logic [CYC_W-1:0] inst_count,
    output logic             overflow,
    output logic             done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CYC_W-1:0] CYC_ONE = {{(CYC_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_CAPTURE = 2'd0,
        S_DRAIN   = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0]       mask;
        logic [3:0]       rdst;
        logic [15:0]      rdata;
        logic [15:0]      maddr;
        logic [15:0]      mdata;
        logic [CYC_W-1:0] cyc;
    } rec_t;

    rec_t        mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    state_t      state;
    logic        pend_valid;
    rec_t        pend_rec;

    rec_t        head;
    rec_t        new_rec;
    rec_t        push_rec;
    logic [3:0]  ev_mask;
    logic        empty;
    logic        full;
    logic        pop;
    logic        can_push;
    logic        capture;
    logic        push;

    assign ev_mask  = {halt, mem_wr, mem_rd, reg_we};
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty && (state != S_DONE);
    assign pop      = out_valid && out_ready;
    // A pop on the same edge frees the slot the push needs.
    assign can_push = !full || pop;
    assign capture  = (state == S_CAPTURE) && en && (|ev_mask);

    // Record fields are zero whenever no record is presented.
    assign out_mask  = out_valid ? head.mask  : 4'd0;
    assign out_reg   = out_valid ? head.rdst  : 4'd0;
    assign out_rdata = out_valid ? head.rdata : 16'd0;
    assign out_maddr = out_valid ? head.maddr : 16'd0;
    assign out_mdata = out_valid ? head.mdata : 16'd0;
    assign out_cycle = out_valid ? head.cyc   : '0;

    // Assemble the record for this cycle and pick what goes into the FIFO.
    always_comb begin
        new_rec.mask  = ev_mask;
        new_rec.rdst  = reg_dst;
        new_rec.rdata = reg_data;
        new_rec.maddr = mem_addr;
        new_rec.mdata = mem_wr ? mem_wdata : mem_rdata;
        new_rec.cyc   = cycle_count;
        push     = 1'b0;
        push_rec = new_rec;
        if (capture && can_push) begin
            push = 1'b1;
        end else if ((state == S_DRAIN) && pend_valid && can_push) begin
            push     = 1'b1;
            push_rec = pend_rec;
        end
    end

    // FIFO storage; contents need no reset since out_valid gates them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= push_rec;
        end
    end

    // Pointers, counters, status and capture state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            state       <= S_CAPTURE;
            pend_valid  <= 1'b0;
            pend_rec    <= '0;
            cycle_count <= '0;
            inst_count  <= '0;
            overflow    <= 1'b0;
            done        <= 1'b0;
        end else begin
            cycle_count <= cycle_count + CYC_ONE;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case (state)
                S_CAPTURE: begin
                    if (capture) begin
                        if (halt || reg_we || mem_wr) begin
                            inst_count <= inst_count + CYC_ONE;
                        end
                        if (!can_push) begin
                            // The halt record must survive a full FIFO.
                            if (halt) begin
                                pend_rec   <= new_rec;
                                pend_valid <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                        end
                        if (halt) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (pend_valid && can_push) begin
                        pend_valid <= 1'b0;
                    end
                    if (pop && head.mask[3]) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                end
                default: state <= S_CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture_unit.sv
// Testbench for trace_capture_unit: directed steps with a reference model
// whose expected records sit in a scoreboard queue until the DUT pops them.
module tb_trace_capture_unit;

    localparam int DEPTH = 8;
    localparam int CYC_W = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic             reg_we = 1'b0;
    logic [3:0]       reg_dst = '0;
    logic [15:0]      reg_data = '0;
    logic             mem_rd = 1'b0;
    logic             mem_wr = 1'b0;
    logic [15:0]      mem_addr = '0;
    logic [15:0]      mem_wdata = '0;
    logic [15:0]      mem_rdata = '0;
    logic             halt = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [3:0]       out_mask;
    logic [3:0]       out_reg;
    logic [15:0]      out_rdata;
    logic [15:0]      out_maddr;
    logic [15:0]      out_mdata;
    logic [CYC_W-1:0] out_cycle;
    logic [CYC_W-1:0] cycle_count;
    logic [CYC_W-1:0] inst_count;
    logic             overflow;
    logic             done;

    trace_capture_unit #(.DEPTH(DEPTH), .CYC_W(CYC_W)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .reg_we(reg_we), .reg_dst(reg_dst), .reg_data(reg_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .halt(halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_reg(out_reg), .out_rdata(out_rdata),
        .out_maddr(out_maddr), .out_mdata(out_mdata), .out_cycle(out_cycle),
        .cycle_count(cycle_count), .inst_count(inst_count),
        .overflow(overflow), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [3:0]  rdst;
        logic [15:0] rdata;
        logic [15:0] maddr;
        logic [15:0] mdata;
        logic [31:0] cyc;
    } rec_t;

    rec_t        sb[$];
    rec_t        m_pend;
    bit          m_pend_v;
    int          m_state;   // 0 capture, 1 drain, 2 done
    logic [31:0] m_cycle;
    logic [31:0] m_inst;
    bit          m_ovf;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        bit ev;
        ev = (sb.size() > 0) && (m_state != 2);
        chk({tag, "_valid"}, out_valid, ev);
        if (ev) begin
            chk({tag, "_mask"},  out_mask,  sb[0].mask);
            chk({tag, "_reg"},   out_reg,   sb[0].rdst);
            chk({tag, "_rdata"}, out_rdata, sb[0].rdata);
            chk({tag, "_maddr"}, out_maddr, sb[0].maddr);
            chk({tag, "_mdata"}, out_mdata, sb[0].mdata);
            chk({tag, "_ocyc"},  out_cycle, sb[0].cyc);
        end
        chk({tag, "_cycle"}, cycle_count, m_cycle);
        chk({tag, "_inst"},  inst_count,  m_inst);
        chk({tag, "_ovf"},   overflow,    m_ovf);
        chk({tag, "_done"},  done,        (m_state == 2));
    endtask

    // Check current outputs, advance the model by one edge, then clock the DUT.
    task automatic tick(input string tag);
        int   n;
        bit   pop;
        bit   room;
        int   nxt;
        rec_t r;
        check_outputs(tag);
        n    = sb.size();
        pop  = (n > 0) && out_ready && (m_state != 2);
        room = (n < DEPTH) || pop;
        nxt  = m_state;
        if (pop) begin
            r = sb.pop_front();
            if (r.mask[3]) nxt = 2;
        end
        if (m_state == 0 && en && (reg_we || mem_rd || mem_wr || halt)) begin
            r.mask  = {halt, mem_wr, mem_rd, reg_we};
            r.rdst  = reg_dst;
            r.rdata = reg_data;
            r.maddr = mem_addr;
            r.mdata = mem_wr ? mem_wdata : mem_rdata;
            r.cyc   = m_cycle;
            if (room) sb.push_back(r);
            else if (halt) begin
                m_pend   = r;
                m_pend_v = 1'b1;
            end else m_ovf = 1'b1;
            if (halt || reg_we || mem_wr) m_inst = m_inst + 1;
            if (halt) nxt = 1;
        end else if (m_state == 1 && m_pend_v && room) begin
            sb.push_back(m_pend);
            m_pend_v = 1'b0;
        end
        m_state = nxt;
        m_cycle = m_cycle + 1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_we = 0; mem_rd = 0; mem_wr = 0; halt = 0;
    endtask

    task automatic reg_write(input logic [3:0] d, input logic [15:0] v);
        idle();
        reg_we = 1; reg_dst = d; reg_data = v;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 0;
        @(posedge clk);
        #1;
        sb.delete();
        m_pend_v = 0; m_state = 0; m_cycle = 0; m_inst = 0; m_ovf = 0;
        chk({tag, "_valid"}, out_valid, 0);
        chk({tag, "_mask"},  out_mask, 0);
        chk({tag, "_reg"},   out_reg, 0);
        chk({tag, "_rdata"}, out_rdata, 0);
        chk({tag, "_maddr"}, out_maddr, 0);
        chk({tag, "_mdata"}, out_mdata, 0);
        chk({tag, "_ocyc"},  out_cycle, 0);
        chk({tag, "_cycle"}, cycle_count, 0);
        chk({tag, "_inst"},  inst_count, 0);
        chk({tag, "_ovf"},   overflow, 0);
        chk({tag, "_done"},  done, 0);
        rst_n = 1;
    endtask

    initial begin
        // Test 1: single register write at cycle_count 5
        do_reset("rst0");
        en = 1; out_ready = 0; idle();
        repeat (5) tick("t1_idle");
        reg_write(4'd3, 16'h1234);
        tick("t1_ev");
        idle();
        chk("t1_ocyc_abs", out_cycle, 5);
        chk("t1_mask_abs", out_mask, 4'b0001);
        chk("t1_inst_abs", inst_count, 1);
        tick("t1_hold");
        out_ready = 1;
        tick("t1_pop");
        chk("t1_empty", out_valid, 0);

        // Test 2: load-to-register, store, load only, both strobes
        out_ready = 0;
        idle();
        reg_we = 1; reg_dst = 4'd5; reg_data = 16'h0101;
        mem_rd = 1; mem_addr = 16'h0040; mem_rdata = 16'hBEEF; mem_wdata = 16'h5555;
        tick("t2_ld");
        idle();
        chk("t2_ld_mask_abs", out_mask, 4'b0011);
        chk("t2_ld_mdata_abs", out_mdata, 16'hBEEF);
        chk("t2_ld_inst_abs", inst_count, 2);
        mem_wr = 1; mem_addr = 16'h0044; mem_wdata = 16'h00A5; mem_rdata = 16'h1111;
        tick("t2_st");
        idle();
        mem_rd = 1; mem_addr = 16'h0048; mem_rdata = 16'h7777;
        tick("t2_rdonly");
        idle();
        mem_rd = 1; mem_wr = 1; mem_addr = 16'h004C; mem_wdata = 16'h0F0F; mem_rdata = 16'hF0F0;
        tick("t2_both");
        idle();
        chk("t2_inst_abs", inst_count, 4);
        out_ready = 1;
        tick("t2_pop1");
        chk("t2_st_mask_abs", out_mask, 4'b0100);
        chk("t2_st_mdata_abs", out_mdata, 16'h00A5);
        repeat (4) tick("t2_drain");

        // Test 3: overflow on the ninth write with the consumer stalled
        do_reset("rst3");
        en = 1; out_ready = 0;
        for (int i = 1; i <= 9; i++) begin
            reg_write(4'(i), 16'(i));
            tick("t3_fill");
        end
        idle();
        chk("t3_ovf_abs", overflow, 1);
        chk("t3_inst_abs", inst_count, 9);
        out_ready = 1;
        repeat (9) tick("t3_drain");
        chk("t3_empty", out_valid, 0);

        // Test 5: push and pop on the same edge while full
        do_reset("rst5");
        en = 1; out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            reg_write(4'(i), 16'h0010 + 16'(i));
            tick("t5_fill");
        end
        out_ready = 1;
        reg_write(4'd9, 16'h0020);
        tick("t5_pushpop");
        idle();
        chk("t5_ovf_abs", overflow, 0);
        repeat (9) tick("t5_drain");
        chk("t5_empty", out_valid, 0);

        // Test 6: reset mid-drain, then events with capture disabled
        do_reset("rst6a");
        en = 1; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            reg_write(4'(i), 16'h0040 + 16'(i));
            tick("t6_fill");
        end
        idle();
        do_reset("rst6b");
        en = 0;
        reg_we = 1; mem_wr = 1; halt = 1; reg_data = 16'hDEAD;
        repeat (4) tick("t6_dis");
        idle();
        chk("t6_cycle_abs", cycle_count, 4);
        chk("t6_inst_abs", inst_count, 0);
        chk("t6_valid_abs", out_valid, 0);

        // Test 4: halt while full, later events ignored, drain to done
        do_reset("rst4");
        en = 1; out_ready = 0;
        for (int i = 0; i < 8; i++) begin
            reg_write(4'(i), 16'h0030 + 16'(i));
            tick("t4_fill");
        end
        idle();
        halt = 1; mem_addr = 16'h00FF;
        tick("t4_halt");
        for (int i = 0; i < 3; i++) begin
            reg_write(4'hE, 16'hEEEE);
            mem_wr = 1;
            tick("t4_ignored");
        end
        idle();
        chk("t4_inst_abs", inst_count, 9);
        chk("t4_ovf_abs", overflow, 0);
        out_ready = 1;
        repeat (8) tick("t4_drain");
        chk("t4_halt_valid_abs", out_valid, 1);
        chk("t4_halt_mask_abs", out_mask, 4'b1000);
        chk("t4_notdone_abs", done, 0);
        tick("t4_halt_pop");
        chk("t4_done_abs", done, 1);
        chk("t4_novalid_abs", out_valid, 0);
        tick("t4_stay");
        check_outputs("t4_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
